// File: rtl/din_debounce_sync_if.sv
// Signal bundle between a raw level source and the debouncer.
// Optional DIN_DEBOUNCE_GLITCH_STATS_EN adds the glitch_cnt statistic.
interface din_debounce_sync_if;
    logic       din;
    logic       d;
    logic       rise;
    logic       fall;
    logic       busy;
`ifdef DIN_DEBOUNCE_GLITCH_STATS_EN
    logic [7:0] glitch_cnt;

    modport master (output din, input d, rise, fall, busy, glitch_cnt);
    modport slave  (input din, output d, rise, fall, busy, glitch_cnt);
`else
    modport master (output din, input d, rise, fall, busy);
    modport slave  (input din, output d, rise, fall, busy);
`endif
endinterface

// File: rtl/din_debounce_sync.sv
// Synchronises and debounces a raw asynchronous level into a clean d plus rise/fall pulses.
// Optional DIN_DEBOUNCE_GLITCH_STATS_EN counts aborted qualifications (saturating, 8 bits).
module din_debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    din_debounce_sync_if.slave bus
);

    typedef enum logic {STABLE, CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   d_q, d_n;
    logic                   rise_q, rise_n;
    logic                   fall_q, fall_n;

    // Only the last synchroniser stage feeds any other logic.
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= STABLE;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.din};
            state_q <= state_n;
            cnt_q   <= cnt_n;
            d_q     <= d_n;
            rise_q  <= rise_n;
            fall_q  <= fall_n;
        end
    end

    always_comb begin
        state_n = STABLE;
        cnt_n   = '0;
        d_n     = d_q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        if (s == d_q) begin
            state_n = STABLE;
        end else if (cnt_q == CNT_LAST) begin
            // Accept: pulses land in the same cycle as the new d.
            d_n    = s;
            rise_n = s;
            fall_n = ~s;
        end else begin
            cnt_n   = cnt_q + CNT_W'(1);
            state_n = CHECK;
        end
    end

    assign bus.d    = d_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = (state_q == CHECK);

`ifdef DIN_DEBOUNCE_GLITCH_STATS_EN
    logic [7:0] glitch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= '0;
        end else if ((state_q == CHECK) && (s == d_q) && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_din_debounce_sync.sv
// Scoreboarded bench: per-edge expected {d,rise,fall,busy} are queued as stimulus is driven.
// Covers STABLE_CYCLES=4 and STABLE_CYCLES=1 instances; stats checks when the macro is defined.
module tb_din_debounce_sync;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [3:0] exp_q [$];
    logic [7:0] gexp_q [$];

    din_debounce_sync_if bus0 ();
    din_debounce_sync_if bus1 ();

    din_debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    din_debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [3:0] tbl [11] = '{4'b0000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                 4'b0001, 4'b1100, 4'b1000, 4'b1000};
        logic [3:0] exp;
        logic [3:0] obs;
        for (int i = 0; i < 11; i++) begin
            reset    = (i < 3);
            bus0.din = 1'b1;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            obs = {bus0.d, bus0.rise, bus0.fall, bus0.busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_rise[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
`ifdef DIN_DEBOUNCE_GLITCH_STATS_EN
        checks++;
        if (bus0.glitch_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_glitch_cnt got=%0d exp=0", bus0.glitch_cnt);
        end
`endif
    endtask

    task automatic test_falling();
        logic [3:0] tbl [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                4'b1001, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] exp;
        logic [3:0] obs;
        for (int i = 0; i < 8; i++) begin
            bus0.din = 1'b0;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            obs = {bus0.d, bus0.rise, bus0.fall, bus0.busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL falling[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] tbl [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] exp;
        logic [3:0] obs;
        for (int i = 0; i < 8; i++) begin
            bus0.din = (i < 3);
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            obs = {bus0.d, bus0.rise, bus0.fall, bus0.busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL glitch[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
`ifdef DIN_DEBOUNCE_GLITCH_STATS_EN
        checks++;
        if (bus0.glitch_cnt !== 8'd1) begin
            failures++;
            $display("FAIL glitch_cnt_one got=%0d exp=1", bus0.glitch_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset();
        // Two qualifying edges (cnt=2), one reset edge, then a full 6-edge rise.
        logic [3:0] tbl [12] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                 4'b0000,
                                 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                 4'b0001, 4'b1100, 4'b1000};
        logic [3:0] exp;
        logic [3:0] obs;
        for (int i = 0; i < 12; i++) begin
            reset    = (i == 4);
            bus0.din = 1'b1;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            obs = {bus0.d, bus0.rise, bus0.fall, bus0.busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL mid_reset[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_stable1();
        logic [3:0] tbl [8] = '{4'b0000, 4'b0000, 4'b1100, 4'b1000,
                                4'b1000, 4'b1000, 4'b0010, 4'b0000};
        logic [3:0] exp;
        logic [3:0] obs;
        for (int i = 0; i < 8; i++) begin
            bus1.din = (i < 4);
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            obs = {bus1.d, bus1.rise, bus1.fall, bus1.busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL stable1[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

`ifdef DIN_DEBOUNCE_GLITCH_STATS_EN
    task automatic test_glitch_saturation();
        logic [7:0] exp;
        reset    = 1'b1;
        bus0.din = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int g = 0; g < 300; g++) begin
            gexp_q.push_back((g + 1 > 255) ? 8'd255 : 8'(g + 1));
            for (int c = 0; c < 7; c++) begin
                bus0.din = (c < 3);
                @(posedge clk);
                #1;
            end
            exp = gexp_q.pop_front();
            checks++;
            if (bus0.glitch_cnt !== exp || bus0.d !== 1'b0) begin
                failures++;
                $display("FAIL glitch_sat[%0d] got=%0d d=%b exp=%0d d=0",
                         g, bus0.glitch_cnt, bus0.d, exp);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus0.glitch_cnt !== 8'd0) begin
            failures++;
            $display("FAIL glitch_sat_reset got=%0d exp=0", bus0.glitch_cnt);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus0.din = 1'b0;
        bus1.din = 1'b0;
        test_reset();
        test_falling();
        test_glitch();
        test_mid_reset();
        test_stable1();
`ifdef DIN_DEBOUNCE_GLITCH_STATS_EN
        test_glitch_saturation();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
